// File: rtl/mem_arbiter_if.sv
// CPU / debug-loader request ports and single-port memory bus
// shared by the memory arbiter and whatever sits around it.
interface mem_arbiter_if;
    logic       cpu_req;
    logic       cpu_we;
    logic [7:0] cpu_adrs;
    logic [7:0] cpu_wdata;
    logic       cpu_gnt;
    logic       cpu_rvalid;
    logic [7:0] cpu_rdata;

    logic       dbg_req;
    logic       dbg_we;
    logic [7:0] dbg_adrs;
    logic [7:0] dbg_wdata;
    logic       dbg_gnt;
    logic       dbg_rvalid;
    logic [7:0] dbg_rdata;

    logic [7:0] mem_adrs;
    logic [7:0] mem_data;
    logic       mem_wr_en;
    logic [7:0] mem_q;
    logic [1:0] owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_adrs, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_adrs, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_adrs, mem_data, mem_wr_en,
        input  mem_q,
        output owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_adrs, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_adrs, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_adrs, mem_data, mem_wr_en,
        output mem_q,
        input  owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / debug loader) arbiter for a single-port
// synchronous memory with a bounded CPU burst while debug waits.
module mem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CPU_ACC = 2'b01,
        DBG_ACC = 2'b10
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t     state;
    state_t     state_nx;
    logic [3:0] burst;
    logic [3:0] burst_nx;
    logic       cpu_elig;
    logic       dbg_elig;

    logic [7:0] adrs_q;
    logic [7:0] data_q;
    logic       wr_en_q;
    logic       cpu_rv_q;
    logic       dbg_rv_q;
    logic [7:0] cpu_rd_q;
    logic [7:0] dbg_rd_q;
    logic [7:0] cpu_rd;
    logic [7:0] dbg_rd;

    // A requester sitting in its grant cycle is not eligible again.
    always_comb begin
        cpu_elig = bus.cpu_req && (state != CPU_ACC);
        dbg_elig = bus.dbg_req && (state != DBG_ACC);
        state_nx = IDLE;
        unique case (1'b1)
            cpu_elig && dbg_elig:
                state_nx = (burst == BURST_MAX) ? DBG_ACC : CPU_ACC;
            cpu_elig && !dbg_elig:
                state_nx = CPU_ACC;
            !cpu_elig && dbg_elig:
                state_nx = DBG_ACC;
            default:
                state_nx = IDLE;
        endcase
    end

    always_comb begin
        burst_nx = burst;
        if (!bus.dbg_req || state_nx == DBG_ACC) begin
            burst_nx = '0;
        end else if (state_nx == CPU_ACC && burst != BURST_MAX) begin
            burst_nx = burst + 4'd1;
        end
    end

    // Read data is passed straight from memory in the rvalid cycle.
    always_comb begin
        cpu_rd = cpu_rv_q ? bus.mem_q : cpu_rd_q;
        dbg_rd = dbg_rv_q ? bus.mem_q : dbg_rd_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            burst    <= '0;
            adrs_q   <= '0;
            data_q   <= '0;
            wr_en_q  <= 1'b0;
            cpu_rv_q <= 1'b0;
            dbg_rv_q <= 1'b0;
            cpu_rd_q <= '0;
            dbg_rd_q <= '0;
        end else begin
            state    <= state_nx;
            burst    <= burst_nx;
            wr_en_q  <= 1'b0;
            unique case (state_nx)
                CPU_ACC: begin
                    adrs_q  <= bus.cpu_adrs;
                    data_q  <= bus.cpu_wdata;
                    wr_en_q <= bus.cpu_we;
                end
                DBG_ACC: begin
                    adrs_q  <= bus.dbg_adrs;
                    data_q  <= bus.dbg_wdata;
                    wr_en_q <= bus.dbg_we;
                end
                default: begin
                end
            endcase
            cpu_rv_q <= (state == CPU_ACC) && !wr_en_q;
            dbg_rv_q <= (state == DBG_ACC) && !wr_en_q;
            cpu_rd_q <= cpu_rd;
            dbg_rd_q <= dbg_rd;
        end
    end

    assign bus.cpu_gnt    = (state == CPU_ACC);
    assign bus.dbg_gnt    = (state == DBG_ACC);
    assign bus.owner      = state;
    assign bus.mem_adrs   = adrs_q;
    assign bus.mem_data   = data_q;
    assign bus.mem_wr_en  = wr_en_q;
    assign bus.cpu_rvalid = cpu_rv_q;
    assign bus.dbg_rvalid = dbg_rv_q;
    assign bus.cpu_rdata  = cpu_rd;
    assign bus.dbg_rdata  = dbg_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory
// model and read-data scoreboards per requester.
module tb_mem_arbiter;

    logic clock;
    logic reset;
    logic preload;
    int   checks;
    int   failures;

    logic [7:0] mem [256];
    logic [7:0] cpu_q [$];
    logic [7:0] dbg_q [$];

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_BURST(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (preload) begin
            mem[8'h10] <= 8'hA5;
            mem[8'h20] <= 8'h11;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_adrs] <= bus.mem_data;
        end
        bus.mem_q <= mem[bus.mem_adrs];
    end

    task automatic check8(input string tag,
                          input logic [7:0] obs,
                          input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we,
                           input logic [7:0] adrs,
                           input logic [7:0] wdata);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_adrs  = adrs;
        bus.cpu_wdata = wdata;
    endtask

    task automatic set_dbg(input logic req, input logic we,
                           input logic [7:0] adrs,
                           input logic [7:0] wdata);
        bus.dbg_req   = req;
        bus.dbg_we    = we;
        bus.dbg_adrs  = adrs;
        bus.dbg_wdata = wdata;
    endtask

    // Scoreboard: every rvalid pops the value queued by the stimulus.
    always @(negedge clock) begin
        if (bus.cpu_rvalid === 1'b1) begin
            if (cpu_q.size() == 0) begin
                check8("cpu_rvalid_spurious", 8'd1, 8'd0);
            end else begin
                check8("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
            end
        end
        if (bus.dbg_rvalid === 1'b1) begin
            if (dbg_q.size() == 0) begin
                check8("dbg_rvalid_spurious", 8'd1, 8'd0);
            end else begin
                check8("dbg_rdata", bus.dbg_rdata, dbg_q.pop_front());
            end
        end
    end

    initial begin
        logic [1:0] own_exp;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        preload  = 1'b1;
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        set_dbg(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) tick;
        preload = 1'b0;

        check8("rst_owner", {6'd0, bus.owner}, 8'h00);
        check8("rst_cpu_gnt", {7'd0, bus.cpu_gnt}, 8'h00);
        check8("rst_dbg_gnt", {7'd0, bus.dbg_gnt}, 8'h00);
        check8("rst_wr_en", {7'd0, bus.mem_wr_en}, 8'h00);
        check8("rst_mem_adrs", bus.mem_adrs, 8'h00);
        check8("rst_mem_data", bus.mem_data, 8'h00);
        check8("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
        check8("rst_dbg_rdata", bus.dbg_rdata, 8'h00);
        reset = 1'b0;
        tick;

        // CPU read alone
        set_cpu(1'b1, 1'b0, 8'h10, 8'h00);
        cpu_q.push_back(8'hA5);
        tick;
        check8("t1_owner", {6'd0, bus.owner}, 8'h01);
        check8("t1_cpu_gnt", {7'd0, bus.cpu_gnt}, 8'h01);
        check8("t1_dbg_gnt", {7'd0, bus.dbg_gnt}, 8'h00);
        check8("t1_mem_adrs", bus.mem_adrs, 8'h10);
        check8("t1_wr_en", {7'd0, bus.mem_wr_en}, 8'h00);
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        check8("t1_idle_owner", {6'd0, bus.owner}, 8'h00);
        check8("t1_idle_adrs_hold", bus.mem_adrs, 8'h10);
        check8("t1_rvalid", {7'd0, bus.cpu_rvalid}, 8'h01);
        tick;
        check8("t1_rvalid_pulse", {7'd0, bus.cpu_rvalid}, 8'h00);
        check8("t1_rdata_hold", bus.cpu_rdata, 8'hA5);

        // Same-cycle debug write and CPU read: CPU first, old data
        set_cpu(1'b1, 1'b0, 8'h20, 8'h00);
        set_dbg(1'b1, 1'b1, 8'h20, 8'h3C);
        cpu_q.push_back(8'h11);
        tick;
        check8("t2_owner_cpu", {6'd0, bus.owner}, 8'h01);
        check8("t2_dbg_gnt_lo", {7'd0, bus.dbg_gnt}, 8'h00);
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        check8("t2_owner_dbg", {6'd0, bus.owner}, 8'h02);
        check8("t2_wr_en", {7'd0, bus.mem_wr_en}, 8'h01);
        check8("t2_mem_adrs", bus.mem_adrs, 8'h20);
        check8("t2_mem_data", bus.mem_data, 8'h3C);
        set_dbg(1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        check8("t2_idle_wr_en", {7'd0, bus.mem_wr_en}, 8'h00);
        check8("t2_idle_owner", {6'd0, bus.owner}, 8'h00);

        // Debug write one cycle earlier: CPU sees new data
        set_dbg(1'b1, 1'b1, 8'h20, 8'h5A);
        tick;
        check8("t2b_owner_dbg", {6'd0, bus.owner}, 8'h02);
        set_dbg(1'b0, 1'b0, 8'h00, 8'h00);
        set_cpu(1'b1, 1'b0, 8'h20, 8'h00);
        cpu_q.push_back(8'h5A);
        tick;
        check8("t2b_owner_cpu", {6'd0, bus.owner}, 8'h01);
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) tick;

        // Both requesters held high continuously
        set_cpu(1'b1, 1'b1, 8'h30, 8'h01);
        set_dbg(1'b1, 1'b1, 8'h31, 8'h02);
        for (int i = 0; i < 10; i++) begin
            tick;
            own_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            check8($sformatf("t3_owner_%0d", i),
                   {6'd0, bus.owner}, {6'd0, own_exp});
        end
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        set_dbg(1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        check8("t3_idle_owner", {6'd0, bus.owner}, 8'h00);
        tick;

        // Both single reads from idle
        set_cpu(1'b1, 1'b0, 8'h30, 8'h00);
        set_dbg(1'b1, 1'b0, 8'h31, 8'h00);
        cpu_q.push_back(8'h01);
        dbg_q.push_back(8'h02);
        tick;
        check8("t4_owner_cpu", {6'd0, bus.owner}, 8'h01);
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        check8("t4_owner_dbg", {6'd0, bus.owner}, 8'h02);
        check8("t4_dbg_adrs", bus.mem_adrs, 8'h31);
        set_dbg(1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        check8("t4_owner_idle", {6'd0, bus.owner}, 8'h00);
        repeat (2) tick;

        // Reset in the CPU read grant cycle
        set_cpu(1'b1, 1'b0, 8'h10, 8'h00);
        tick;
        check8("t5_cpu_gnt", {7'd0, bus.cpu_gnt}, 8'h01);
        reset = 1'b1;
        tick;
        check8("t5_owner", {6'd0, bus.owner}, 8'h00);
        check8("t5_cpu_gnt_lo", {7'd0, bus.cpu_gnt}, 8'h00);
        check8("t5_rvalid", {7'd0, bus.cpu_rvalid}, 8'h00);
        check8("t5_mem_adrs", bus.mem_adrs, 8'h00);
        check8("t5_mem_data", bus.mem_data, 8'h00);
        check8("t5_wr_en", {7'd0, bus.mem_wr_en}, 8'h00);
        check8("t5_cpu_rdata", bus.cpu_rdata, 8'h00);
        check8("t5_dbg_rdata", bus.dbg_rdata, 8'h00);
        reset = 1'b0;
        cpu_q.push_back(8'hA5);
        tick;
        check8("t5_regrant", {6'd0, bus.owner}, 8'h01);
        check8("t5_regrant_adrs", bus.mem_adrs, 8'h10);
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) tick;

        check8("cpu_q_left", 8'(cpu_q.size()), 8'd0);
        check8("dbg_q_left", 8'(dbg_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
